// File: rtl/upcounter_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : upcounter_timer_ctrl
// Purpose  : Programmable interval timer. A prescaler chain produces a tick
//            every (prescale+1) clocks. Each tick advances a ripple-enable
//            binary up-counter. When a tick arrives while count equals the
//            latched period, the controller pulses done and reloads the
//            count to 0. It then either keeps running (auto-reload) or
//            returns to IDLE (one-shot).
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-low reset
//            start      - pulse: (re)start, latch period/prescale/oneshot
//            stop       - pulse: return to IDLE, clear counts
//            pause      - level: freeze counting while high
//            oneshot    - 1 = stop after first match, 0 = auto-reload
//            period     - terminal count compared against count
//            prescale   - tick every prescale+1 clocks
//            count      - current main count
//            busy       - high in RUN or PAUSE
//            done       - one-cycle registered pulse on period match
//            state      - FSM encoding (IDLE=00, RUN=01, PAUSE=10)
//            cap_strobe / cap_value / cap_valid - count capture, present
//            only when UPCOUNTER_TIMER_CAPTURE_EN is defined
// Options  : UPCOUNTER_TIMER_CAPTURE_EN enables the capture register
// Revision : 1.0 - initial release
// ============================================================================
module upcounter_timer_ctrl #(
    parameter int BITS     = 8,
    parameter int PRE_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic                oneshot,
    input  logic [BITS-1:0]     period,
    input  logic [PRE_BITS-1:0] prescale,
`ifdef UPCOUNTER_TIMER_CAPTURE_EN
    input  logic                cap_strobe,
    output logic [BITS-1:0]     cap_value,
    output logic                cap_valid,
`endif
    output logic [BITS-1:0]     count,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t              r_state;
    logic [BITS-1:0]     r_count;
    logic [PRE_BITS-1:0] r_pre;
    logic [BITS-1:0]     r_period_l;
    logic [PRE_BITS-1:0] r_prescale_l;
    logic                r_oneshot_l;
    logic                r_done;

    logic                w_tick;
    logic                w_match;
    logic [BITS-1:0]     w_cnt_tgl;
    logic [BITS-1:0]     w_count_inc;
    logic [PRE_BITS-1:0] w_pre_tgl;
    logic [PRE_BITS-1:0] w_pre_inc;

    assign w_tick  = (r_pre == r_prescale_l);
    assign w_match = w_tick && (r_count == r_period_l);

    // Main count: bit i toggles when the tick enable is present and every
    // lower bit is 1 (ripple enable chain).
    genvar gi;
    generate
        for (gi = 0; gi < BITS; gi++) begin : g_cnt
            if (gi == 0) begin : g_lsb
                assign w_cnt_tgl[gi] = w_tick;
            end else begin : g_upper
                assign w_cnt_tgl[gi] = w_cnt_tgl[gi-1] & r_count[gi-1];
            end
        end
        // Prescaler: same chain with the enable tied high.
        for (gi = 0; gi < PRE_BITS; gi++) begin : g_pre
            if (gi == 0) begin : g_lsb
                assign w_pre_tgl[gi] = 1'b1;
            end else begin : g_upper
                assign w_pre_tgl[gi] = w_pre_tgl[gi-1] & r_pre[gi-1];
            end
        end
    endgenerate

    assign w_count_inc = r_count ^ w_cnt_tgl;
    assign w_pre_inc   = r_pre ^ w_pre_tgl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_pre        <= '0;
            r_period_l   <= '0;
            r_prescale_l <= '0;
            r_oneshot_l  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (stop) begin
                        r_count <= '0;
                        r_pre   <= '0;
                    end else if (start) begin
                        r_period_l   <= period;
                        r_prescale_l <= prescale;
                        r_oneshot_l  <= oneshot;
                        r_count      <= '0;
                        r_pre        <= '0;
                        r_state      <= RUN;
                    end
                end
                RUN, PAUSE: begin
                    if (stop) begin
                        r_count <= '0;
                        r_pre   <= '0;
                        r_state <= IDLE;
                    end else if (start) begin
                        // Restart wins over any match in this cycle.
                        r_period_l   <= period;
                        r_prescale_l <= prescale;
                        r_oneshot_l  <= oneshot;
                        r_count      <= '0;
                        r_pre        <= '0;
                        r_state      <= RUN;
                    end else if (pause) begin
                        r_state <= PAUSE;
                    end else begin
                        // Leaving PAUSE counts in the same cycle, so the
                        // shift equals the number of cycles pause was high.
                        r_state <= RUN;
                        if (w_tick) begin
                            r_pre <= '0;
                            if (w_match) begin
                                r_count <= '0;
                                r_done  <= 1'b1;
                                if (r_oneshot_l) begin
                                    r_state <= IDLE;
                                end
                            end else begin
                                r_count <= w_count_inc;
                            end
                        end else begin
                            r_pre <= w_pre_inc;
                        end
                    end
                end
                default: begin
                    // Illegal encoding 2'b11 recovers to IDLE.
                    r_state <= IDLE;
                    r_count <= '0;
                    r_pre   <= '0;
                end
            endcase
        end
    end

`ifdef UPCOUNTER_TIMER_CAPTURE_EN
    logic [BITS-1:0] r_cap_value;
    logic            r_cap_valid;

    // Captures the pre-reload count, so a strobe on a match returns period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cap_value <= '0;
            r_cap_valid <= 1'b0;
        end else if (start) begin
            r_cap_value <= '0;
            r_cap_valid <= 1'b0;
        end else if (cap_strobe && (r_state == RUN || r_state == PAUSE)) begin
            r_cap_value <= r_count;
            r_cap_valid <= 1'b1;
        end
    end

    assign cap_value = r_cap_value;
    assign cap_valid = r_cap_valid;
`endif

    assign count = r_count;
    assign busy  = (r_state != IDLE);
    assign done  = r_done;
    assign state = r_state;

endmodule
`default_nettype wire

// File: doc/upcounter_timer_ctrl.md
Name: upcounter_timer_ctrl

Overview:
- Programmable interval timer controller that sequences a ripple-enable binary up-counter.
- Built from a prescaler stage and a main count stage, each a chain of toggle bits gated by an enable chain.
- Adds start/stop/pause control, period compare with auto-reload or one-shot mode, and a one-cycle done pulse.
- Sits between a register/config block and the counter datapath; used for periodic ticks, timeouts and PWM periods.

Parameters:
BITS, 8, width of main count and period compare value
PRE_BITS, 4, width of prescaler divide value

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse, (re)starts timer, latches period/prescale/oneshot
stop  input  1  single-cycle pulse, returns to IDLE, clears counts
pause  input  1  level; while high in RUN, counting frozen
oneshot  input  1  1 = stop after first period match, 0 = auto-reload
period  input  BITS  terminal count; match when count == period
prescale  input  PRE_BITS  tick every prescale+1 clk cycles
count  output  BITS  current main count
busy  output  1  high in RUN or PAUSE
done  output  1  one-cycle pulse on period match
state  output  2  FSM state encoding

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, count=0, prescaler=0, done=0, busy=0, latched config=0. Takes effect immediately, including mid-count.
- State encoding: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10. 2'b11 is illegal and recovers to IDLE on the next clk.
- IDLE:
  - start -> RUN next cycle.
  - Latch period, prescale, oneshot; clear count and prescaler.
- RUN:
  - Prescaler increments each clk.
  - When prescaler == latched prescale: tick=1 and prescaler wraps to 0.
  - On tick, count increments (enable chain: bit i toggles when ena and all lower bits are 1).
  - Period match: tick while count == latched period.
    - done=1 for exactly that cycle.
    - count reloads to 0, not period+1.
    - oneshot=1 -> IDLE next cycle with count=0.
    - oneshot=0 -> stay in RUN.
  - pause=1 -> PAUSE. Prescaler and count hold; no tick is taken in the cycle pause is sampled high.
- PAUSE:
  - pause=0 -> RUN, resuming from the held prescaler/count.
  - stop and start are honoured as in RUN.
- Priority (same cycle): stop > start > pause > tick.
  - stop with start -> IDLE.
  - start in RUN or PAUSE -> restart: relatch config, clear counts, go to RUN; no done for that cycle.
- Latency:
  - start to first tick = prescale+1 cycles.
  - start to first done = (period+1)*(prescale+1) cycles.
- Boundaries:
  - period=0: done on every tick.
  - prescale=0: tick every clk.
  - period = 2^BITS-1: count runs through all values and wraps to 0 with done.
  - Config inputs changing during RUN have no effect until the next start.
- busy = (state != IDLE). done is registered, never combinational from inputs.

Optional Feature:
- Macro: UPCOUNTER_TIMER_CAPTURE_EN
- Defined: adds ports
  - cap_strobe (input, 1)
  - cap_value (output, BITS)
  - cap_valid (output, 1)
- Capture rules:
  - cap_strobe high in RUN or PAUSE latches count into cap_value and sets cap_valid next cycle.
  - A strobe coincident with a period match captures the pre-reload value (== period).
  - start or reset clears cap_value=0 and cap_valid=0.
  - Strobe in IDLE is ignored.
- Undefined: ports and capture logic absent; remaining behaviour identical.

Test Plan:
- Reset mid-RUN (count=5): drive rst low asynchronously between edges -> count=0, state=00, busy=0 immediately.
- BITS=8, prescale=0, period=3, oneshot=0, start pulse:
  - count sequence 0,1,2,3,0,1...
  - done high on every 4th cycle, first at cycle 4 after start.
  - busy stays 1.
- prescale=2, period=1, oneshot=1:
  - count changes every 3 clk.
  - single done 6 cycles after start, then state=00 and count=0; no further done.
- pause high 5 cycles at count=2 -> count held at 2 and prescaler held; after release, done timing is shifted by exactly 5 cycles.
- Same-cycle events:
  - stop+start together -> IDLE.
  - start during RUN at count=7 -> count=0 next cycle, new period in effect, no done.
- Capture build: cap_strobe at count=9 -> cap_value=9, cap_valid=1 next cycle. Next start -> cap_valid=0.
